// File: rtl/alu_tmp_flags_if.sv
// Control and observation signals of the SAP-2 ALU stage.
// The shared W bus is a tri-state net and stays a plain inout port on the block.
interface alu_tmp_flags_if;
    logic [7:0] iAcc;
    logic       iLoadTmp;
    logic       iExecute;
    logic [3:0] iOp;
    logic       iEnable;
    logic [7:0] oResult;
    logic [7:0] oTmp;
    logic       oSign;
    logic       oZero;
    logic       oCarry;

    modport master (
        output iAcc, iLoadTmp, iExecute, iOp, iEnable,
        input  oResult, oTmp, oSign, oZero, oCarry
    );

    modport slave (
        input  iAcc, iLoadTmp, iExecute, iOp, iEnable,
        output oResult, oTmp, oSign, oZero, oCarry
    );
endinterface

// File: rtl/alu_tmp_flags.sv
// SAP-2 arithmetic/logic stage: TMP operand register, 8-bit ALU, registered
// result with sign/zero/carry flags, and a tri-state driver onto the W bus.
module alu_tmp_flags (
    input  logic            iClk,
    input  logic            iClr,
    inout  tri   [7:0]      iotData,
    alu_tmp_flags_if.slave  alu
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_CMA  = 4'd5,
        OP_RAL  = 4'd6,
        OP_RAR  = 4'd7,
        OP_INR  = 4'd8,
        OP_DCR  = 4'd9,
        OP_MOVT = 4'd10
    } aluOp_e;

    logic [7:0] tmpQ;
    logic [7:0] resultQ;
    logic       signQ;
    logic       zeroQ;
    logic       carryQ;

    logic [7:0] aluRes;
    logic       aluCarry;
    logic [8:0] sum9;
    logic [8:0] diff9;

    // ALU datapath; ops 11-15 fall through to passing A.
    always_comb begin
        aluRes   = alu.iAcc;
        aluCarry = 1'b0;
        // Bit 8 of the sum is the carry out; bit 8 of the difference is the borrow.
        sum9     = {1'b0, alu.iAcc} + {1'b0, tmpQ};
        diff9    = {1'b0, alu.iAcc} - {1'b0, tmpQ};
        case (aluOp_e'(alu.iOp))
            OP_ADD:  begin aluRes = sum9[7:0];  aluCarry = sum9[8];  end
            OP_SUB:  begin aluRes = diff9[7:0]; aluCarry = diff9[8]; end
            OP_AND:  aluRes = alu.iAcc & tmpQ;
            OP_OR:   aluRes = alu.iAcc | tmpQ;
            OP_XOR:  aluRes = alu.iAcc ^ tmpQ;
            OP_CMA:  aluRes = ~alu.iAcc;
            OP_RAL:  begin aluRes = {alu.iAcc[6:0], alu.iAcc[7]}; aluCarry = alu.iAcc[7]; end
            OP_RAR:  begin aluRes = {alu.iAcc[0], alu.iAcc[7:1]}; aluCarry = alu.iAcc[0]; end
            OP_INR:  begin aluRes = alu.iAcc + 8'd1; aluCarry = (alu.iAcc == 8'hFF); end
            OP_DCR:  begin aluRes = alu.iAcc - 8'd1; aluCarry = (alu.iAcc == 8'h00); end
            OP_MOVT: aluRes = tmpQ;
            default: aluRes = alu.iAcc;
        endcase
    end

    // TMP loads from the resolved bus, so a load while enabled captures our own result.
    always_ff @(posedge iClk or posedge iClr) begin
        if (iClr)
            tmpQ <= 8'h00;
        else if (alu.iLoadTmp)
            tmpQ <= iotData;
    end

    // Result and flags; execute sees TMP from before the edge even on a simultaneous load.
    always_ff @(posedge iClk or posedge iClr) begin
        if (iClr) begin
            resultQ <= 8'h00;
            signQ   <= 1'b0;
            zeroQ   <= 1'b0;
            carryQ  <= 1'b0;
        end else if (alu.iExecute) begin
            resultQ <= aluRes;
            signQ   <= aluRes[7];
            zeroQ   <= (aluRes == 8'h00);
            carryQ  <= aluCarry;
        end
    end

    // Bus driver depends only on iEnable; during reset it drives the cleared result.
    assign iotData = alu.iEnable ? resultQ : 8'hzz;

    assign alu.oResult = resultQ;
    assign alu.oTmp    = tmpQ;
    assign alu.oSign   = signQ;
    assign alu.oZero   = zeroQ;
    assign alu.oCarry  = carryQ;
endmodule

// File: tb/tb_alu_tmp_flags.sv
// Directed bench for alu_tmp_flags: execute results go through a scoreboard
// queue checked by a monitor one edge later; register/bus checks are inline.
module tb_alu_tmp_flags;
    typedef struct {
        logic [7:0] res;
        logic       s;
        logic       z;
        logic       c;
        logic [7:0] tmp;
    } exp_t;

    logic       clk;
    logic       clr;
    tri   [7:0] wbus;
    logic [7:0] tbDrv;
    logic       tbDrvEn;
    logic       execD;
    int         total;
    int         bad;
    exp_t       sbq[$];

    alu_tmp_flags_if ifc ();

    assign wbus = tbDrvEn ? tbDrv : 8'hzz;

    alu_tmp_flags dut (
        .iClk    (clk),
        .iClr    (clr),
        .iotData (wbus),
        .alu     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks that an execute was taken on the last rising edge.
    always @(posedge clk or posedge clr) begin
        if (clr) execD <= 1'b0;
        else     execD <= ifc.iExecute;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed execute.
    always @(negedge clk) begin
        if (execD) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got execute expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", ifc.oResult, e.res);
                check("sign",   {7'd0, ifc.oSign},  {7'd0, e.s});
                check("zero",   {7'd0, ifc.oZero},  {7'd0, e.z});
                check("carry",  {7'd0, ifc.oCarry}, {7'd0, e.c});
                check("tmp",    ifc.oTmp, e.tmp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadTmp(input logic [7:0] v);
        tbDrv = v; tbDrvEn = 1'b1; ifc.iLoadTmp = 1'b1;
        step();
        ifc.iLoadTmp = 1'b0; tbDrvEn = 1'b0;
        check("tmp_load", ifc.oTmp, v);
    endtask

    task automatic exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] r,
                        input logic s, input logic z, input logic c, input logic [7:0] t);
        exp_t e;
        e.res = r; e.s = s; e.z = z; e.c = c; e.tmp = t;
        sbq.push_back(e);
        ifc.iAcc = a; ifc.iOp = op; ifc.iExecute = 1'b1;
        step();
        ifc.iExecute = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic checkCleared(input string tag);
        check({tag, "_res"},   ifc.oResult, 8'h00);
        check({tag, "_tmp"},   ifc.oTmp, 8'h00);
        check({tag, "_flags"}, {5'd0, ifc.oSign, ifc.oZero, ifc.oCarry}, 8'h00);
    endtask

    initial begin
        total = 0; bad = 0;
        tbDrv = 8'h00; tbDrvEn = 1'b0;
        ifc.iAcc = 8'h00; ifc.iLoadTmp = 1'b0; ifc.iExecute = 1'b0;
        ifc.iOp = 4'd0; ifc.iEnable = 1'b0;
        clr = 1'b1;
        repeat (2) step();
        checkCleared("rst0");
        clr = 1'b0;

        // ADD wrap, then write back onto the bus
        loadTmp(8'h01);
        exec(4'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01);
        ifc.iEnable = 1'b1; #1;
        check("bus_add", wbus, 8'h00);
        ifc.iEnable = 1'b0;

        // SUB with and without borrow
        loadTmp(8'h05);
        exec(4'd1, 8'h03, 8'hFE, 1'b1, 1'b0, 1'b1, 8'h05);
        exec(4'd1, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05);

        // rotates and complement
        exec(4'd6, 8'h81, 8'h03, 1'b0, 1'b0, 1'b1, 8'h05);
        exec(4'd7, 8'h81, 8'hC0, 1'b1, 1'b0, 1'b1, 8'h05);
        exec(4'd5, 8'h81, 8'h7E, 1'b0, 1'b0, 1'b0, 8'h05);

        // INR/DCR boundaries
        exec(4'd8, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05);
        exec(4'd9, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h05);
        exec(4'd8, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 8'h05);

        // logic ops, MOVT, PASS (A=0Fh, T=05h)
        exec(4'd2,  8'h0F, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05);
        exec(4'd3,  8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h05);
        exec(4'd4,  8'h0F, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h05);
        exec(4'd10, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0, 8'h05);
        exec(4'd12, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h05);
        exec(4'd15, 8'hA0, 8'hA0, 1'b1, 1'b0, 1'b0, 8'h05);

        // bus driven with result when enabled, released when not
        ifc.iEnable = 1'b1; #1;
        check("bus_drive", wbus, 8'hA0);
        ifc.iEnable = 1'b0; tbDrv = 8'h5A; tbDrvEn = 1'b1; #1;
        check("bus_release", wbus, 8'h5A);
        tbDrvEn = 1'b0;

        // simultaneous load and execute: execute uses old TMP
        loadTmp(8'h10);
        tbDrv = 8'h20; tbDrvEn = 1'b1; ifc.iLoadTmp = 1'b1;
        exec(4'd0, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0, 8'h20);
        ifc.iLoadTmp = 1'b0; tbDrv = 8'h5A;
        ifc.iAcc = 8'hEE; ifc.iOp = 4'd5;
        repeat (3) step();
        check("hold_res", ifc.oResult, 8'h11);
        check("hold_tmp", ifc.oTmp, 8'h20);
        check("hold_flags", {5'd0, ifc.oSign, ifc.oZero, ifc.oCarry}, 8'h00);
        check("hold_bus", wbus, 8'h5A);
        tbDrvEn = 1'b0;

        // execute while enabled: old result before the edge, new after
        ifc.iEnable = 1'b1; #1;
        check("bus_old", wbus, 8'h11);
        exec(4'd12, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 8'h20);
        check("bus_new", wbus, 8'h33);

        // load while enabled: TMP captures own result
        ifc.iLoadTmp = 1'b1;
        step();
        ifc.iLoadTmp = 1'b0;
        check("tmp_self", ifc.oTmp, 8'h33);

        // asynchronous reset mid-cycle, strobes ignored while held
        @(posedge clk); #2;
        clr = 1'b1; #1;
        checkCleared("rst1");
        check("rst_bus", wbus, 8'h00);
        ifc.iExecute = 1'b1; ifc.iLoadTmp = 1'b1; ifc.iAcc = 8'h77; ifc.iOp = 4'd15;
        step();
        checkCleared("rst2");
        ifc.iExecute = 1'b0; ifc.iLoadTmp = 1'b0; ifc.iEnable = 1'b0;
        #2 clr = 1'b0;

        // first edge after release acts normally
        exec(4'd8, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00);

        repeat (2) step();
        check("sb_drained", 8'(sbq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
